// File: rtl/seg7_pkg.sv
// Shared definitions for the scanned 7-segment ALU display: result width,
// operation encodings and the hex-to-segment table.
package seg7_pkg;

  // Result width for a given operand width: wide enough for 16*Y+X and 8*X+Y.
  function automatic int ow_of(input int w);
    return 2 * w + 2;
  endfunction

  typedef enum logic [1:0] {
    SEL_X8_ADD_Y  = 2'b00,  // 8*X + Y
    SEL_Y16_ADD_X = 2'b01,  // 16*Y + X
    SEL_X_SHL_Y   = 2'b10,  // X << Y
    SEL_Y_SHR_X   = 2'b11   // Y >> X
  } sel_e;

  // Segment patterns {g,f,e,d,c,b,a}, 1 = lit, indexed by hex digit value.
  localparam logic [6:0] HEX_SEG [0:15] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex digit to 7-segment pattern decoder.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one hex digit.
  always_comb begin
    seg = HEX_SEG[nib];
  end

endmodule

// File: rtl/seg7_scan_alu.sv
// Small registered ALU whose result is shown on a multiplexed 7-segment
// display, one digit per prescaler period, with optional leading-zero blanking.
module seg7_scan_alu
  import seg7_pkg::*;
#(
  parameter  int W    = 3,
  parameter  int NDIG = 8,
  parameter  int DIV  = 50000,
  localparam int OW   = ow_of(W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    X,
  input  logic [W-1:0]    Y,
  input  logic [1:0]      sel,
  input  logic            load,
  input  logic            blank_en,
  output logic [OW-1:0]   out,
  output logic            done,
  output logic [6:0]      DN0,
  output logic [NDIG-1:0] seg_en
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);

  logic [OW-1:0] out_q, out_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [OW-1:0] x_ext, y_ext, alu_res;
  logic [31:0]   shl_amt, shr_amt;
  logic          tick;

  // Operation result; operands are zero-extended to OW and out-of-range
  // shift amounts flush to zero rather than wrapping.
  always_comb begin
    x_ext   = OW'(X);
    y_ext   = OW'(Y);
    shl_amt = 32'(Y);
    shr_amt = 32'(X);
    alu_res = '0;
    case (sel_e'(sel))
      SEL_X8_ADD_Y:  alu_res = (x_ext << 3) + y_ext;
      SEL_Y16_ADD_X: alu_res = (y_ext << 4) + x_ext;
      SEL_X_SHL_Y:   alu_res = (shl_amt >= 32'(OW)) ? '0 : (x_ext << shl_amt);
      SEL_Y_SHR_X:   alu_res = (shr_amt >= 32'(OW)) ? '0 : (y_ext >> shr_amt);
      default:       alu_res = '0;
    endcase
  end

  // Next-state: capture on load, refresh prescaler, digit index advance on tick.
  always_comb begin
    tick   = (cnt_q == CNT_MAX);
    out_d  = load ? alu_res : out_q;
    done_d = load;
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // State registers with immediate clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= '0;
    end else begin
      out_q  <= out_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;

  // Display side: split the zero-padded result into nibbles and flag, per
  // digit, whether that nibble or any more significant one is non-zero.
  logic [4*NDIG-1:0] out_pad;
  logic [3:0]        nib [NDIG];
  logic [NDIG-1:0]   any_hi;

  assign out_pad = (4*NDIG)'(out_q);

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_nib
    assign nib[gi]    = out_pad[4*gi +: 4];
    assign any_hi[gi] = |out_pad[4*NDIG-1 : 4*gi];
  end

  logic [3:0] nib_sel;
  logic [6:0] seg_dec;
  logic       blanked;

  assign nib_sel = nib[idx_q];

  seg7_hex_decoder u_dec (
    .nib (nib_sel),
    .seg (seg_dec)
  );

  // Digit drive: one-hot enable and decoded pattern, both suppressed when the
  // current digit is a leading zero (digit 0 always shown).
  always_comb begin
    blanked = blank_en && (idx_q != '0) && !any_hi[idx_q];
    seg_en  = blanked ? '0 : (NDIG'(1) << idx_q);
    DN0     = blanked ? 7'b0 : seg_dec;
  end

endmodule

// File: tb/tb_seg7_scan_alu.sv
// Directed bench for seg7_scan_alu with W=3, NDIG=8, DIV=4.
module tb_seg7_scan_alu;

  localparam int W    = 3;
  localparam int NDIG = 8;
  localparam int DIV  = 4;
  localparam int OW   = 2 * W + 2;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;

  logic            clk;
  logic            rst_n;
  logic [W-1:0]    X;
  logic [W-1:0]    Y;
  logic [1:0]      sel;
  logic            load;
  logic            blank_en;
  logic [OW-1:0]   out;
  logic            done;
  logic [6:0]      DN0;
  logic [NDIG-1:0] seg_en;

  int total = 0;
  int bad   = 0;
  int ecount = 0;

  seg7_scan_alu #(.W(W), .NDIG(NDIG), .DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .X        (X),
    .Y        (Y),
    .sel      (sel),
    .load     (load),
    .blank_en (blank_en),
    .out      (out),
    .done     (done),
    .DN0      (DN0),
    .seg_en   (seg_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    $display("chk %-14s obs=0x%0h exp=0x%0h", tag, obs, exp);
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  // Advance until the bench's own scan model says digit slot/prescaler phase.
  task automatic goto_slot(input int slot, input int c);
    int n;
    n = 0;
    while (!((((ecount / DIV) % NDIG) == slot) && ((ecount % DIV) == c)) && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic do_load(input logic [1:0] s, input logic [W-1:0] xv, input logic [W-1:0] yv);
    sel = s; X = xv; Y = yv; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b1; blank_en = 1'b0;
    sel = 2'b00; X = 3'd5; Y = 3'd3;
    #1;
    check("rst_out", 32'(out), 32'h00);
    check("rst_done", 32'(done), 32'h0);
    check("rst_seg_en", 32'(seg_en), 32'h01);
    check("rst_dn0", 32'(DN0), 32'(SEG_0));
    repeat (2) step();
    check("rst_load_ign", 32'(out), 32'h00);
    check("rst_done_ign", 32'(done), 32'h0);

    // Release reset and watch the scan sequence.
    rst_n = 1'b1; load = 1'b0;
    ecount = 0;
    repeat (3) step();
    check("scan_c3", 32'(seg_en), 32'h01);
    step();
    check("scan_c4", 32'(seg_en), 32'h02);
    goto_slot(6, 3);
    check("scan_c27", 32'(seg_en), 32'h40);
    step();
    check("scan_c28", 32'(seg_en), 32'h80);
    check("scan_c28_dn", 32'(DN0), 32'(SEG_0));
    repeat (3) step();
    check("scan_c31", 32'(seg_en), 32'h80);
    step();
    check("scan_c32", 32'(seg_en), 32'h01);

    // ALU operations.
    do_load(2'b00, 3'd5, 3'd3);
    check("op00_out", 32'(out), 32'h2B);
    check("op00_done", 32'(done), 32'h1);
    step();
    check("done_clear", 32'(done), 32'h0);
    check("hold_2b", 32'(out), 32'h2B);

    load = 1'b1;
    sel = 2'b01; X = 3'd7; Y = 3'd7; step();
    check("op01_77", 32'(out), 32'h77);
    check("held_done1", 32'(done), 32'h1);
    sel = 2'b10; X = 3'd7; Y = 3'd6; step();
    check("op10_c0", 32'(out), 32'hC0);
    check("held_done2", 32'(done), 32'h1);
    sel = 2'b10; X = 3'd1; Y = 3'd7; step();
    check("op10_80", 32'(out), 32'h80);
    sel = 2'b11; X = 3'd1; Y = 3'd6; step();
    check("op11_03", 32'(out), 32'h03);
    sel = 2'b11; X = 3'd7; Y = 3'd7; step();
    check("op11_00", 32'(out), 32'h00);
    sel = 2'b00; X = 3'd7; Y = 3'd7; step();
    check("op00_3f", 32'(out), 32'h3F);
    load = 1'b0; X = 3'd0; Y = 3'd0; step();
    check("hold_3f", 32'(out), 32'h3F);
    check("hold_done0", 32'(done), 32'h0);

    // Leading-zero blanking with out = 0x05.
    do_load(2'b00, 3'd0, 3'd5);
    check("load_05", 32'(out), 32'h05);
    blank_en = 1'b1;
    goto_slot(0, 0);
    check("blk_s0_en", 32'(seg_en), 32'h01);
    check("blk_s0_dn", 32'(DN0), 32'(SEG_5));
    for (int k = 1; k < NDIG; k++) begin
      goto_slot(k, 0);
      check($sformatf("blk_s%0d_en", k), 32'(seg_en), 32'h00);
      check($sformatf("blk_s%0d_dn", k), 32'(DN0), 32'h00);
    end
    goto_slot(1, 2);
    blank_en = 1'b0;
    #1;
    check("noblk_s1_en", 32'(seg_en), 32'h02);
    check("noblk_s1_dn", 32'(DN0), 32'(SEG_0));

    // Two significant nibbles: 0x2B.
    do_load(2'b00, 3'd5, 3'd3);
    blank_en = 1'b1;
    goto_slot(0, 1);
    check("2b_s0_en", 32'(seg_en), 32'h01);
    check("2b_s0_dn", 32'(DN0), 32'(SEG_B));
    goto_slot(1, 0);
    check("2b_s1_en", 32'(seg_en), 32'h02);
    check("2b_s1_dn", 32'(DN0), 32'(SEG_2));
    goto_slot(2, 0);
    check("2b_s2_en", 32'(seg_en), 32'h00);
    check("2b_s2_dn", 32'(DN0), 32'h00);

    // Capture on the tick edge: next digit shows the new value at once.
    goto_slot(0, 3);
    do_load(2'b10, 3'd7, 3'd6);
    check("tick_ld_out", 32'(out), 32'hC0);
    check("tick_ld_done", 32'(done), 32'h1);
    check("tick_ld_en", 32'(seg_en), 32'h02);
    check("tick_ld_dn", 32'(DN0), 32'(SEG_C));

    // Asynchronous reset in the middle of slot 5.
    do_load(2'b00, 3'd5, 3'd3);
    blank_en = 1'b0;
    goto_slot(5, 1);
    check("pre_rst_en", 32'(seg_en), 32'h20);
    check("pre_rst_out", 32'(out), 32'h2B);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", 32'(out), 32'h00);
    check("arst_done", 32'(done), 32'h0);
    check("arst_en", 32'(seg_en), 32'h01);
    check("arst_dn", 32'(DN0), 32'(SEG_0));
    #1;
    rst_n = 1'b1;
    ecount = 0;
    repeat (3) step();
    check("post_rst_c3", 32'(seg_en), 32'h01);
    step();
    check("post_rst_c4", 32'(seg_en), 32'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
